// File: rtl/led_pkg.sv
// Shared definitions for the LED frame scanner: default geometry and the scan FSM states.
package led_pkg;

    localparam int DEF_LED_NUM = 64;
    localparam int DEF_IDX_W   = 6;
    localparam int DEF_DATA_W  = 24;

    // One state per pipeline stage of a single pixel fetch, plus the idle/wait states.
    typedef enum logic [2:0] {
        IDLE,
        MAP,
        WADDR,
        RD,
        CAP,
        SEND
    } scan_state_e;

endpackage

// File: rtl/led_scan_ctrl.sv
// Frame scanner: walks LED indices through the mapper, fetches each pixel from frame RAM
// and streams it to the encoder, one pixel in flight at a time.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int LED_NUM = DEF_LED_NUM,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              map_en_out,
    output logic [IDX_W-1:0]  map_idx_out,
    input  logic [IDX_W-1:0]  map_addr_in,
    output logic              ram_rd_en_out,
    output logic [IDX_W-1:0]  ram_rd_addr_out,
    input  logic [DATA_W-1:0] ram_rd_data_in,
    output logic              pix_valid_out,
    output logic [DATA_W-1:0] pix_data_out,
    output logic              pix_last_out,
    input  logic              pix_ready_in
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_NUM - 1);

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              map_en_q, map_en_d;
    logic              rd_en_q, rd_en_d;
    logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    // Strobes (map_en, rd_en, done) default low so each is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        map_en_d  = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    map_en_d = 1'b1;
                    state_d  = MAP;
                end
            end
            MAP: begin
                state_d = WADDR;
            end
            WADDR: begin
                rd_addr_d = map_addr_in;
                rd_en_d   = 1'b1;
                state_d   = RD;
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                data_d  = ram_rd_data_in;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST_IDX);
                state_d = SEND;
            end
            SEND: begin
                // The next index is only mapped after the current pixel has left.
                if (valid_q && pix_ready_in) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        map_en_d = 1'b1;
                        state_d  = MAP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            map_en_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            map_en_q  <= map_en_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign map_en_out      = map_en_q;
    assign map_idx_out     = idx_q;
    assign ram_rd_en_out   = rd_en_q;
    assign ram_rd_addr_out = rd_addr_q;
    assign pix_valid_out   = valid_q;
    assign pix_data_out    = data_q;
    assign pix_last_out    = last_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: a 64-LED scanner and a 2-LED scanner share one clock,
// each fed by a registered mapper model and a registered frame-RAM model.
module tb_led_scan_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int edgeCount = 0;

    logic        resetA = 1'b1, startA = 1'b0, readyA = 1'b1, mapMode = 1'b0;
    logic        busyA, doneA, mapEnA, rdEnA, pixValidA, pixLastA;
    logic [5:0]  mapIdxA, rdAddrA, mapAddrA = '0;
    logic [23:0] ramDataA = '0, pixDataA;

    logic        resetB = 1'b1, startB = 1'b0, readyB = 1'b1;
    logic        busyB, doneB, mapEnB, rdEnB, pixValidB, pixLastB;
    logic [5:0]  mapIdxB, rdAddrB, mapAddrB = '0;
    logic [23:0] ramDataB = '0, pixDataB;

    logic [23:0] xferDataA[$], xferDataB[$];
    logic        xferLastA[$], xferLastB[$];
    int          xferEdgeA[$], xferEdgeB[$];
    int          doneCountA = 0;

    led_scan_ctrl dutA (
        .clk_in(clock), .rst_in(resetA), .start_in(startA),
        .busy_out(busyA), .done_out(doneA),
        .map_en_out(mapEnA), .map_idx_out(mapIdxA), .map_addr_in(mapAddrA),
        .ram_rd_en_out(rdEnA), .ram_rd_addr_out(rdAddrA), .ram_rd_data_in(ramDataA),
        .pix_valid_out(pixValidA), .pix_data_out(pixDataA), .pix_last_out(pixLastA),
        .pix_ready_in(readyA)
    );

    led_scan_ctrl #(.LED_NUM(2)) dutB (
        .clk_in(clock), .rst_in(resetB), .start_in(startB),
        .busy_out(busyB), .done_out(doneB),
        .map_en_out(mapEnB), .map_idx_out(mapIdxB), .map_addr_in(mapAddrB),
        .ram_rd_en_out(rdEnB), .ram_rd_addr_out(rdAddrB), .ram_rd_data_in(ramDataB),
        .pix_valid_out(pixValidB), .pix_data_out(pixDataB), .pix_last_out(pixLastB),
        .pix_ready_in(readyB)
    );

    // Serpentine rows of 8: odd rows run right-to-left.
    function automatic logic [5:0] mapFn(input logic [5:0] idx, input logic serp);
        if (serp && idx[3])
            return {idx[5:3], ~idx[2:0]};
        return idx;
    endfunction

    function automatic logic [23:0] ramFn(input logic [5:0] addr);
        logic [23:0] v;
        v = {18'b0, addr};
        return v * 24'h010203;
    endfunction

    // Registered mapper/RAM models plus a transfer recorder tagged with the edge index.
    always @(posedge clock) begin
        edgeCount <= edgeCount + 1;
        if (mapEnA) mapAddrA <= mapFn(mapIdxA, mapMode);
        if (rdEnA)  ramDataA <= ramFn(rdAddrA);
        if (mapEnB) mapAddrB <= mapFn(mapIdxB, 1'b0);
        if (rdEnB)  ramDataB <= ramFn(rdAddrB);
        if (pixValidA && readyA) begin
            xferDataA.push_back(pixDataA);
            xferLastA.push_back(pixLastA);
            xferEdgeA.push_back(edgeCount);
        end
        if (pixValidB && readyB) begin
            xferDataB.push_back(pixDataB);
            xferLastB.push_back(pixLastB);
            xferEdgeB.push_back(edgeCount);
        end
        if (doneA) doneCountA <= doneCountA + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic start, input logic ready);
        resetA = rst;
        startA = start;
        readyA = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZeroA(input string tag);
        checkOutput({tag, ".busy"}, busyA, 0);
        checkOutput({tag, ".done"}, doneA, 0);
        checkOutput({tag, ".mapEn"}, mapEnA, 0);
        checkOutput({tag, ".mapIdx"}, mapIdxA, 0);
        checkOutput({tag, ".rdEn"}, rdEnA, 0);
        checkOutput({tag, ".rdAddr"}, rdAddrA, 0);
        checkOutput({tag, ".valid"}, pixValidA, 0);
        checkOutput({tag, ".data"}, pixDataA, 0);
        checkOutput({tag, ".last"}, pixLastA, 0);
    endtask

    task automatic waitDoneA(input int limit);
        for (int n = 0; n < limit && !doneA; n++) tick();
    endtask

    task automatic waitPixelA(input logic [5:0] idx, input int limit);
        for (int n = 0; n < limit && !(pixValidA && mapIdxA == idx); n++) tick();
    endtask

    initial begin
        int startEdge, base, lastCount, doneBefore;

        // Reset both scanners and check every output is cleared.
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        checkAllZeroA("reset");
        checkOutput("resetB.busy", busyB, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        resetB = 1'b0;
        tick();

        // Frame 1: identity mapper, ready tied high, pipeline latency walk.
        $display("[TB] frame 1: identity mapping");
        base = xferDataA.size();
        startA = 1'b1; tick(); startA = 1'b0;
        startEdge = edgeCount - 1;
        checkOutput("f1.c1.busy", busyA, 1);
        checkOutput("f1.c1.mapEn", mapEnA, 1);
        checkOutput("f1.c1.mapIdx", mapIdxA, 0);
        tick();
        checkOutput("f1.c2.mapEn", mapEnA, 0);
        checkOutput("f1.c2.rdEn", rdEnA, 0);
        tick();
        checkOutput("f1.c3.rdEn", rdEnA, 1);
        checkOutput("f1.c3.rdAddr", rdAddrA, 0);
        tick();
        checkOutput("f1.c4.rdEn", rdEnA, 0);
        checkOutput("f1.c4.valid", pixValidA, 0);
        tick();
        checkOutput("f1.c5.valid", pixValidA, 1);
        checkOutput("f1.c5.data", pixDataA, 0);
        checkOutput("f1.c5.last", pixLastA, 0);
        waitDoneA(400);
        checkOutput("f1.done", doneA, 1);
        checkOutput("f1.doneLatency", 32'(edgeCount - 1 - startEdge), 320);
        checkOutput("f1.busyAtDone", busyA, 0);
        checkOutput("f1.count", 32'(xferDataA.size() - base), 64);
        if (xferDataA.size() >= base + 64) begin
            lastCount = 0;
            for (int k = 0; k < 64; k++) begin
                checkOutput($sformatf("f1.data%0d", k), xferDataA[base + k], ramFn(6'(k)));
                if (xferLastA[base + k]) lastCount++;
            end
            checkOutput("f1.data63const", xferDataA[base + 63], 24'h3F7EBD);
            checkOutput("f1.lastCount", lastCount, 1);
            checkOutput("f1.lastOn63", xferLastA[base + 63], 1);
            checkOutput("f1.edge0", 32'(xferEdgeA[base] - startEdge), 5);
            checkOutput("f1.edge63", 32'(xferEdgeA[base + 63] - startEdge), 320);
        end
        tick();
        checkOutput("f1.donePulse", doneA, 0);

        // Frame 2: serpentine mapper.
        $display("[TB] frame 2: serpentine mapping");
        mapMode = 1'b1;
        base = xferDataA.size();
        startA = 1'b1; tick(); startA = 1'b0;
        waitDoneA(400);
        checkOutput("f2.done", doneA, 1);
        checkOutput("f2.count", 32'(xferDataA.size() - base), 64);
        if (xferDataA.size() >= base + 64) begin
            checkOutput("f2.px0", xferDataA[base + 0], 24'h000000);
            checkOutput("f2.px7", xferDataA[base + 7], 24'h070E15);
            checkOutput("f2.px8", xferDataA[base + 8], 24'h0F1E2D);
            checkOutput("f2.px9", xferDataA[base + 9], 24'h0E1C2A);
            checkOutput("f2.px15", xferDataA[base + 15], 24'h081018);
        end
        mapMode = 1'b0;
        tick();

        // Frame 3: backpressure for 10 cycles on pixel 3.
        $display("[TB] frame 3: backpressure");
        base = xferDataA.size();
        startA = 1'b1; tick(); startA = 1'b0;
        startEdge = edgeCount - 1;
        repeat (18) tick();
        checkOutput("f3.c19.valid", pixValidA, 0);
        readyA = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("f3.hold%0d.valid", i), pixValidA, 1);
            checkOutput($sformatf("f3.hold%0d.data", i), pixDataA, 24'h030609);
            checkOutput($sformatf("f3.hold%0d.noReq", i), mapEnA | rdEnA, 0);
            if (i == 9) readyA = 1'b1;
            tick();
        end
        checkOutput("f3.c30.mapEn", mapEnA, 1);
        checkOutput("f3.c30.mapIdx", mapIdxA, 4);
        repeat (4) tick();
        checkOutput("f3.c34.valid", pixValidA, 1);
        checkOutput("f3.c34.data", pixDataA, 24'h04080C);
        waitDoneA(400);
        checkOutput("f3.done", doneA, 1);
        checkOutput("f3.count", 32'(xferDataA.size() - base), 64);
        if (xferDataA.size() >= base + 5) begin
            checkOutput("f3.edge3", 32'(xferEdgeA[base + 3] - startEdge), 29);
            checkOutput("f3.gap34", 32'(xferEdgeA[base + 4] - xferEdgeA[base + 3]), 5);
        end
        tick();

        // Frame 4: start mid-frame ignored, start during done accepted.
        $display("[TB] frame 4: start handling");
        base = xferDataA.size();
        startA = 1'b1; tick(); startA = 1'b0;
        waitPixelA(6'd20, 200);
        checkOutput("f4.reach20", pixValidA, 1);
        startA = 1'b1; tick(); startA = 1'b0;
        checkOutput("f4.ignoredIdx", mapIdxA, 21);
        checkOutput("f4.ignoredBusy", busyA, 1);
        waitDoneA(400);
        checkOutput("f4.done", doneA, 1);
        checkOutput("f4.count", 32'(xferDataA.size() - base), 64);
        startA = 1'b1; tick(); startA = 1'b0;
        checkOutput("f4.restart.mapEn", mapEnA, 1);
        checkOutput("f4.restart.mapIdx", mapIdxA, 0);
        checkOutput("f4.restart.busy", busyA, 1);
        checkOutput("f4.restart.done", doneA, 0);

        // Reset while sending pixel 30 of the restarted frame.
        $display("[TB] frame 5: reset mid-frame");
        waitPixelA(6'd30, 300);
        checkOutput("f5.reach30", pixValidA, 1);
        doneBefore = doneCountA;
        resetA = 1'b1; tick(); resetA = 1'b0;
        checkAllZeroA("f5.afterReset");
        repeat (10) tick();
        checkOutput("f5.noDone", 32'(doneCountA - doneBefore), 0);
        checkOutput("f5.idleBusy", busyA, 0);
        base = xferDataA.size();
        startA = 1'b1; tick(); startA = 1'b0;
        checkOutput("f5.restart.mapEn", mapEnA, 1);
        checkOutput("f5.restart.mapIdx", mapIdxA, 0);
        waitDoneA(400);
        checkOutput("f5.done", doneA, 1);
        checkOutput("f5.count", 32'(xferDataA.size() - base), 64);
        if (xferDataA.size() > base)
            checkOutput("f5.px0", xferDataA[base], 24'h000000);

        // Two-LED scanner.
        $display("[TB] frame 6: LED_NUM=2");
        startB = 1'b1; tick(); startB = 1'b0;
        startEdge = edgeCount - 1;
        for (int n = 0; n < 50 && !doneB; n++) tick();
        checkOutput("b.done", doneB, 1);
        checkOutput("b.doneLatency", 32'(edgeCount - 1 - startEdge), 10);
        checkOutput("b.busy", busyB, 0);
        checkOutput("b.count", xferDataB.size(), 2);
        if (xferDataB.size() >= 2) begin
            checkOutput("b.px0", xferDataB[0], 24'h000000);
            checkOutput("b.px1", xferDataB[1], 24'h010203);
            checkOutput("b.last0", xferLastB[0], 0);
            checkOutput("b.last1", xferLastB[1], 1);
        end
        tick();
        checkOutput("b.donePulse", doneB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
